// File: rtl/noc_adder_node.sv
// noc_adder_node
// Compute endpoint of the NoC adder. It collects one A and one B operand flit
// from the router ejection port in either order. It adds them and injects a
// single result flit addressed to RESULT_DEST.
//
// Ports
//   CLK, RST       clock, asynchronous active-high reset
//   S_TVALID/READY operand flit handshake
//   S_TDATA        [OPW-1:0] operand value, [TDATAW-1] tag (0=A, 1=B)
//   M_TVALID/READY result flit handshake
//   M_TDATA        [OPW:0] zero-extended sum, upper bits zero
//   M_TDEST        constant RESULT_DEST
//   DONE           one-cycle pulse after each result handshake
//   SUM_COUNT      completed result handshakes, wraps modulo 2^CNTW
//   ERR_DUP        sticky flag: an operand arrived whose tag was already held
module noc_adder_node #(
  parameter int TDATAW      = 64,
  parameter int TDESTW      = 4,
  parameter int OPW         = 8,
  parameter int RESULT_DEST = 0,
  parameter int CNTW        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  input  logic [TDATAW-1:0] S_TDATA,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic [TDATAW-1:0] M_TDATA,
  output logic [TDESTW-1:0] M_TDEST,
  output logic              DONE,
  output logic [CNTW-1:0]   SUM_COUNT,
  output logic              ERR_DUP
);

  typedef enum logic [1:0] {IDLE, HAVE_A, HAVE_B, SEND} state_t;

  // Zero-extended add: the carry lands in bit OPW, so nothing is lost.
  function automatic logic [OPW:0] add_ext(input logic [OPW-1:0] x,
                                           input logic [OPW-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  state_t          state, state_d;
  logic [OPW-1:0]  op_a, op_b;
  logic [OPW-1:0]  operand, held;
  logic            tag;
  logic            in_hs, out_hs;
  logic            ld_a, ld_b, ld_sum, dup;
  logic [OPW:0]    sum_d;
  logic [OPW:0]    sum_p1;
  logic            vld_p1;
  logic            done_p2;
  logic [CNTW-1:0] count;
  logic            err;
  logic            unused_bits;

  assign operand     = S_TDATA[OPW-1:0];
  assign tag         = S_TDATA[TDATAW-1];
  assign unused_bits = ^S_TDATA[TDATAW-2:OPW];

  // S_TREADY is the only output decoded from the state register. It is held
  // low while RST is asserted so no flit is taken during reset.
  assign S_TREADY = (state != SEND) && !RST;
  assign in_hs    = S_TVALID && S_TREADY;
  assign out_hs   = vld_p1 && M_TREADY;

  // The held operand is the one the incoming flit will be added to.
  assign held  = (state == HAVE_A) ? op_a : op_b;
  assign sum_d = add_ext(held, operand);

  always_comb begin
    state_d = state;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_sum  = 1'b0;
    dup     = 1'b0;
    case (state)
      IDLE: begin
        if (in_hs) begin
          if (tag) begin
            ld_b    = 1'b1;
            state_d = HAVE_B;
          end else begin
            ld_a    = 1'b1;
            state_d = HAVE_A;
          end
        end
      end
      HAVE_A: begin
        if (in_hs) begin
          if (tag) begin
            ld_sum  = 1'b1;
            state_d = SEND;
          end else begin
            ld_a = 1'b1;
            dup  = 1'b1;
          end
        end
      end
      HAVE_B: begin
        if (in_hs) begin
          if (!tag) begin
            ld_sum  = 1'b1;
            state_d = SEND;
          end else begin
            ld_b = 1'b1;
            dup  = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      sum_p1  <= '0;
      vld_p1  <= 1'b0;
      done_p2 <= 1'b0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_d;
      if (ld_a) op_a <= operand;
      if (ld_b) op_b <= operand;
      // p1: result register, held stable until the downstream accepts it
      if (ld_sum) begin
        sum_p1 <= sum_d;
        vld_p1 <= 1'b1;
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
      // p2: completion pulse and counter, one cycle after the handshake
      done_p2 <= out_hs;
      if (out_hs) count <= count + 1'b1;
      if (dup) err <= 1'b1;
    end
  end

  assign M_TVALID  = vld_p1;
  assign M_TDATA   = {{(TDATAW-OPW-1){1'b0}}, sum_p1};
  assign M_TDEST   = TDESTW'(RESULT_DEST);
  assign DONE      = done_p2;
  assign SUM_COUNT = count;
  assign ERR_DUP   = err;

endmodule
